// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mips_bus_arbiter                                           |
// | Description : Two-master arbiter for the MIPS CPU memory bus. m0 is      |
// |               instruction fetch and m1 is data load/store. One           |
// |               transaction at a time, registered read return with a       |
// |               one-cycle valid strobe, and a sticky slave-stall timeout.  |
// |               Define MIPS_BUS_ARB_ROUND_ROBIN_EN for round-robin          |
// |               arbitration; default is fixed priority (m1 wins).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mips_bus_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [31:0]       m0_writedata,
   input  logic [3:0]        m0_byteenable,
   output logic              m0_waitrequest,
   output logic [31:0]       m0_readdata,
   output logic              m0_readdatavalid,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [31:0]       m1_writedata,
   input  logic [3:0]        m1_byteenable,
   output logic              m1_waitrequest,
   output logic [31:0]       m1_readdata,
   output logic              m1_readdatavalid,
   output logic [ADDR_W-1:0] address,
   output logic              read,
   output logic              write,
   output logic [31:0]       writedata,
   output logic [3:0]        byteenable,
   input  logic              waitrequest,
   input  logic [31:0]       readdata,
   output logic              timeout
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Counter wide enough to reach TIMEOUT_CYCLES-1; a disabled timeout
   // still gets a 1-bit saturating counter.
   localparam int CNT_W     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int ONE_I     = 1;
   localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE = ONE_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [31:0]      FORCED_DATA = 32'hDEADBEEF;

   logic [1:0]        r_state, w_next_state;
   logic              r_grant;        // 0 = m0, 1 = m1
   logic              r_last_grant;
   logic              w_pick;
   logic [CNT_W-1:0]  r_wait_cnt;
   logic              w_req0, w_req1;
   logic [ADDR_W-1:0] w_g_addr;
   logic              w_g_read, w_g_write;
   logic [31:0]       w_g_wdata;
   logic [3:0]        w_g_be;
   logic              w_active, w_accept, w_stall, w_expire, w_abort;

   assign w_req0 = m0_read | m0_write;
   assign w_req1 = m1_read | m1_write;

   // Granted master's request, muxed once for the bus and the FSM.
   assign w_g_addr  = r_grant ? m1_address    : m0_address;
   assign w_g_read  = r_grant ? m1_read       : m0_read;
   assign w_g_write = r_grant ? m1_write      : m0_write;
   assign w_g_wdata = r_grant ? m1_writedata  : m0_writedata;
   assign w_g_be    = r_grant ? m1_byteenable : m0_byteenable;

   assign w_active = w_g_read | w_g_write;
   assign w_abort  = (r_state == S_BUSY) && !w_active;
   assign w_accept = (r_state == S_BUSY) && w_active && !waitrequest;
   assign w_stall  = (r_state == S_BUSY) && w_active && waitrequest;
   assign w_expire = w_stall && (TIMEOUT_CYCLES != 0) && (r_wait_cnt == TO_LAST);

   // Arbitration winner among the requests seen in IDLE.
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
   always_comb begin
      w_pick = w_req1;
      if (w_req0 && w_req1)
         w_pick = ~r_last_grant;
   end
`else
   // Fixed priority: data side always wins; last grant is tracked only.
   assign w_pick = w_req1;
   logic w_unused_last_grant;
   assign w_unused_last_grant = r_last_grant;
`endif

   // State register and grant latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_IDLE && (w_req0 || w_req1)) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
         end
      end
   end

   // Next-state logic; a timeout acts as a forced acceptance that skips RESP.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (w_req0 || w_req1) w_next_state = S_BUSY;
         S_BUSY: begin
            if (w_abort || w_expire)
               w_next_state = S_IDLE;
            else if (w_accept)
               w_next_state = w_g_write ? S_IDLE : S_RESP;
         end
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Bus and requester handshake outputs; only BUSY drives the bus.
   always_comb begin
      address        = '0;
      read           = 1'b0;
      write          = 1'b0;
      writedata      = '0;
      byteenable     = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      if (r_state == S_BUSY) begin
         address    = w_g_addr;
         read       = w_g_read & ~w_g_write;   // write wins over read
         write      = w_g_write;
         writedata  = w_g_wdata;
         byteenable = w_g_be;
         if (r_grant) m1_waitrequest = waitrequest;
         else         m0_waitrequest = waitrequest;
      end
   end

   // Stall counter: counts consecutive stalled BUSY cycles, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_wait_cnt <= '0;
      else if (!w_stall || w_expire)
         r_wait_cnt <= '0;
      else if (r_wait_cnt != CNT_MAX)
         r_wait_cnt <= r_wait_cnt + CNT_ONE;
   end

   // Sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         timeout <= 1'b0;
      else if (w_expire)
         timeout <= 1'b1;
   end

   // Read return: capture slave data in RESP, or the marker on a forced read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_readdata      <= '0;
         m1_readdata      <= '0;
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
      end else begin
         m0_readdatavalid <= 1'b0;
         m1_readdatavalid <= 1'b0;
         if (r_state == S_RESP || (w_expire && !w_g_write)) begin
            if (r_grant) begin
               m1_readdata      <= (r_state == S_RESP) ? readdata : FORCED_DATA;
               m1_readdatavalid <= 1'b1;
            end else begin
               m0_readdata      <= (r_state == S_RESP) ? readdata : FORCED_DATA;
               m0_readdatavalid <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mips_bus_arbiter                                        |
// | Description : Self-checking bench for mips_bus_arbiter: table of single  |
// |               transactions plus stall, contention, timeout and reset     |
// |               sequences. Follows MIPS_BUS_ARB_ROUND_ROBIN_EN if defined.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mips_bus_arbiter;

   localparam logic [31:0] JUNK = 32'h0BAD0BAD;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] m0_address = '0, m1_address = '0;
   logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
   logic [31:0] m0_writedata = '0, m1_writedata = '0;
   logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
   logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
   logic [31:0] m0_readdata, m1_readdata;
   logic [31:0] address, writedata;
   logic        read, write, timeout;
   logic [3:0]  byteenable;
   logic        waitrequest = 1'b0;
   logic [31:0] readdata = JUNK;

   int n_chk = 0;
   int n_fail = 0;
   logic exp_last;

   mips_bus_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m0_readdatavalid(m0_readdatavalid),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .m1_readdatavalid(m1_readdatavalid),
      .address(address), .read(read), .write(write), .writedata(writedata),
      .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata),
      .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          m1;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] sdata;
      bit          exp_read;
      bit          exp_write;
      bit          exp_rdv;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit m1, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      if (m1) begin
         m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
      end else begin
         m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
      end
   endtask

   task automatic release_all();
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
   endtask

   // One lone transaction with no slave stall, called right after a posedge.
   task automatic run_vec(input vec_t v);
      drive(v.m1, v.rd, v.wr, v.addr, v.wdata, v.be);
      waitrequest = 1'b0;
      readdata    = JUNK;
      @(negedge clk);
      chk("idle_bus_read", {31'd0, read}, 32'd0);
      step();
      @(negedge clk);
      chk("busy_read", {31'd0, read}, {31'd0, v.exp_read});
      chk("busy_write", {31'd0, write}, {31'd0, v.exp_write});
      chk("busy_address", address, v.addr);
      chk("busy_writedata", writedata, v.wdata);
      chk("busy_byteenable", {28'd0, byteenable}, {28'd0, v.be});
      chk("grant_wait", {31'd0, v.m1 ? m1_waitrequest : m0_waitrequest}, 32'd0);
      chk("other_wait", {31'd0, v.m1 ? m0_waitrequest : m1_waitrequest}, 32'd1);
      step();
      release_all();
      readdata = v.sdata;
      @(negedge clk);
      chk("after_accept_bus", {30'd0, read, write}, 32'd0);
      step();
      readdata = JUNK;
      @(negedge clk);
      chk("rdv", {31'd0, v.m1 ? m1_readdatavalid : m0_readdatavalid}, {31'd0, v.exp_rdv});
      chk("other_rdv", {31'd0, v.m1 ? m0_readdatavalid : m1_readdatavalid}, 32'd0);
      if (v.exp_rdv)
         chk("rdata", v.m1 ? m1_readdata : m0_readdata, v.exp_rdata);
      step();
      @(negedge clk);
      chk("rdv_pulse_end", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      step();
   endtask

   initial begin
      //          m1 rd wr addr          wdata         be    sdata         er ew ev exp_rdata
      vecs[0] = '{0, 1, 0, 32'hBFC00000, 32'h00000000, 4'hF, 32'h3C08BFC0, 1, 0, 1, 32'h3C08BFC0};
      vecs[1] = '{1, 0, 1, 32'h00001000, 32'h0000002C, 4'hF, 32'h11111111, 0, 1, 0, 32'h00000000};
      vecs[2] = '{1, 1, 0, 32'h10000004, 32'h00000000, 4'hF, 32'h12345678, 1, 0, 1, 32'h12345678};
      vecs[3] = '{0, 1, 1, 32'h00000040, 32'hA5A5A5A5, 4'h3, 32'h22222222, 0, 1, 0, 32'h00000000};
      vecs[4] = '{1, 1, 1, 32'h00000080, 32'h01020304, 4'hC, 32'h33333333, 0, 1, 0, 32'h00000000};
      vecs[5] = '{0, 1, 0, 32'hBFC00004, 32'h00000000, 4'hF, 32'hCAFEF00D, 1, 0, 1, 32'hCAFEF00D};

      // Reset values while reset is held low.
      @(negedge clk);
      chk("rst_bus", {30'd0, read, write}, 32'd0);
      chk("rst_address", address, 32'd0);
      chk("rst_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
      chk("rst_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      chk("rst_m0_rdata", m0_readdata, 32'd0);
      chk("rst_m1_rdata", m1_readdata, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      step();
      reset = 1'b1;
      step();

      for (int i = 0; i < 6; i++)
         run_vec(vecs[i]);

      // Simultaneous reads with m0 holding its request: m1 first, then m0.
      drive(0, 1, 0, 32'h000000A0, 32'd0, 4'hF);
      drive(1, 1, 0, 32'h000000A4, 32'd0, 4'hF);
      step();
      @(negedge clk);
      chk("sim_first_m1_wait", {31'd0, m1_waitrequest}, 32'd0);
      chk("sim_first_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
      chk("sim_first_addr", address, 32'h000000A4);
      step();
      m1_read = 1'b0;
      readdata = 32'hD1D1D1D1;
      step();
      readdata = JUNK;
      @(negedge clk);
      chk("sim_m1_rdv", {31'd0, m1_readdatavalid}, 32'd1);
      chk("sim_m1_rdata", m1_readdata, 32'hD1D1D1D1);
      step();
      @(negedge clk);
      chk("sim_second_m0_wait", {31'd0, m0_waitrequest}, 32'd0);
      chk("sim_second_addr", address, 32'h000000A0);
      step();
      m0_read = 1'b0;
      readdata = 32'hD0D0D0D0;
      step();
      readdata = JUNK;
      @(negedge clk);
      chk("sim_m0_rdv", {31'd0, m0_readdatavalid}, 32'd1);
      chk("sim_m0_rdata", m0_readdata, 32'hD0D0D0D0);
      step();

      // Stalled write from m1: three stall cycles, then acceptance.
      drive(1, 0, 1, 32'h00000100, 32'h0000002C, 4'hF);
      waitrequest = 1'b1;
      step();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_m1_wait", {31'd0, m1_waitrequest}, 32'd1);
         chk("stall_write", {31'd0, write}, 32'd1);
         chk("stall_wdata", writedata, 32'h0000002C);
         chk("stall_addr", address, 32'h00000100);
         step();
      end
      waitrequest = 1'b0;
      @(negedge clk);
      chk("stall_release_wait", {31'd0, m1_waitrequest}, 32'd0);
      step();
      release_all();
      @(negedge clk);
      chk("stall_done_write", {31'd0, write}, 32'd0);
      chk("stall_done_wait", {31'd0, m1_waitrequest}, 32'd1);
      chk("stall_no_timeout", {31'd0, timeout}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         chk("stall_no_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
      end
      step();

      // Contended rounds: each loser withdraws, so the winner history is
      // exactly the sequence of contended grants. Last grant so far is m1.
      exp_last = 1'b1;
      for (int r = 0; r < 4; r++) begin
         logic w;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
         w = ~exp_last;
`else
         w = 1'b1;
`endif
         exp_last = w;
         drive(0, 1, 0, 32'h00000200, 32'd0, 4'hF);
         drive(1, 1, 0, 32'h00000300, 32'd0, 4'hF);
         step();
         @(negedge clk);
         chk("rr_winner_wait", {31'd0, w ? m1_waitrequest : m0_waitrequest}, 32'd0);
         chk("rr_loser_wait", {31'd0, w ? m0_waitrequest : m1_waitrequest}, 32'd1);
         chk("rr_addr", address, w ? 32'h00000300 : 32'h00000200);
         step();
         release_all();
         readdata = 32'h5A000000 + r;
         step();
         readdata = JUNK;
         @(negedge clk);
         chk("rr_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, w ? 32'd2 : 32'd1);
         step();
      end

      // Timeout: m0 read stuck behind waitrequest for four cycles.
      drive(0, 1, 0, 32'h00000400, 32'd0, 4'hF);
      waitrequest = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to_pending", {31'd0, timeout}, 32'd0);
         chk("to_m0_wait", {31'd0, m0_waitrequest}, 32'd1);
         chk("to_read", {31'd0, read}, 32'd1);
         step();
      end
      release_all();
      waitrequest = 1'b0;
      @(negedge clk);
      chk("to_flag", {31'd0, timeout}, 32'd1);
      chk("to_rdv", {31'd0, m0_readdatavalid}, 32'd1);
      chk("to_rdata", m0_readdata, 32'hDEADBEEF);
      chk("to_bus_idle", {31'd0, read}, 32'd0);
      step();
      @(negedge clk);
      chk("to_rdv_end", {31'd0, m0_readdatavalid}, 32'd0);
      step();
      run_vec(vecs[1]);
      @(negedge clk);
      chk("to_sticky", {31'd0, timeout}, 32'd1);
      step();

      // Reset in the middle of a stalled read.
      drive(0, 1, 0, 32'h00000500, 32'd0, 4'hF);
      waitrequest = 1'b1;
      step();
      @(negedge clk);
      chk("mid_read_busy", {31'd0, read}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_read", {31'd0, read}, 32'd0);
      chk("mid_rst_wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
      chk("mid_rst_timeout", {31'd0, timeout}, 32'd0);
      release_all();
      waitrequest = 1'b0;
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_rst_no_rdv", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
         step();
      end
      run_vec(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single CPU memory bus (read/write/waitrequest handshake, 32-bit word data, 4-bit byteenable) between two requesters: m0 = instruction fetch, m1 = data load/store.
- Sits between the fetch/LSU units of mips_cpu_bus and the external memory port.
- Grants one transaction at a time, forwards the slave handshake, returns registered read data with a valid pulse, and flags slave stalls that exceed a timeout.

Parameters:
- ADDR_W, 32, address width of masters and bus.
- TIMEOUT_CYCLES, 255, maximum consecutive bus waitrequest cycles before timeout; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_address / m1_address  in  ADDR_W  requester byte address.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_writedata / m1_writedata  in  32  write data.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_waitrequest / m1_waitrequest  out  1  stall to requester.
- m0_readdata / m1_readdata  out  32  returned read data.
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read return strobe.
- address  out  ADDR_W  bus address.
- read  out  1  bus read.
- write  out  1  bus write.
- writedata  out  32  bus write data.
- byteenable  out  4  bus byte lanes.
- waitrequest  in  1  slave stall.
- readdata  in  32  slave data, valid the cycle after read acceptance.
- timeout  out  1  sticky timeout flag.

Behaviour:
- Reset values (immediate, asynchronous):
  - state = IDLE.
  - address, read, write, writedata, byteenable = 0.
  - m*_waitrequest = 1.
  - m*_readdata = 0, m*_readdatavalid = 0.
  - timeout = 0, wait counter = 0, last_grant = m0.
- Request rule: a requester is requesting when its read or write is high. If read and write are both high, write wins and read is ignored.
- IDLE:
  - Bus outputs are 0; both m*_waitrequest = 1.
  - If any request is present, latch the winner and go to BUSY.
  - Arbitration decision latency is 1 cycle.
- BUSY (granted master g):
  - Bus outputs mirror g's inputs combinationally.
  - g_waitrequest = bus waitrequest; the other master's waitrequest = 1.
  - Transaction is accepted when the bus waitrequest is 0 at a clock edge.
  - Accepted write: go to IDLE.
  - Accepted read: go to RESP.
  - If g drops both read and write before acceptance: abort to IDLE; no data is returned.
- RESP:
  - Bus outputs are 0.
  - Register bus readdata into g_readdata and pulse g_readdatavalid for exactly 1 cycle, on the cycle after RESP.
  - Then go to IDLE.
  - Read latency from acceptance to readdatavalid: 2 cycles.
- m*_readdata holds its last value between pulses.
- Timeout:
  - The counter increments each BUSY cycle with waitrequest = 1 and clears on acceptance or abort.
  - When it reaches TIMEOUT_CYCLES (nonzero): set timeout (sticky until reset), force acceptance, go to IDLE.
  - A forced read returns readdatavalid with data 0xDEADBEEF.
  - The counter saturates; it never wraps.
- Back-to-back: minimum 2 cycles per write (IDLE + BUSY) and 3 per read.
- Reset mid-transaction: abandons the transaction with no readdatavalid; the bus deasserts asynchronously.

Optional Feature:
- Macro: MIPS_BUS_ARB_ROUND_ROBIN_EN.
- Defined: when both masters request in IDLE, grant the master that is not last_grant. last_grant updates on every grant.
- Undefined: fixed priority, m1 (data) always beats m0. last_grant is still tracked but unused.
- A lone requester is granted immediately in both modes.

Test Plan:
- Single read, no stall:
  - Stimulus: m0_read=1, m0_address=0xBFC00000, slave waitrequest=0, slave readdata=0x3C08BFC0.
  - Response: bus read high 1 cycle after request; m0_readdatavalid pulses 2 cycles after acceptance with m0_readdata=0x3C08BFC0; m1_waitrequest stays 1.
- Stalled write:
  - Stimulus: m1_write=1, m1_writedata=0x0000002C, m1_byteenable=0xF, slave waitrequest=1 for 3 cycles.
  - Response: m1_waitrequest=1 for those 3 cycles; bus signals held stable; one write accepted; no readdatavalid.
- Simultaneous requests:
  - Stimulus: m0 and m1 read at the same time.
  - Response without macro: m1 granted first, then m0.
  - Response with MIPS_BUS_ARB_ROUND_ROBIN_EN and 4 repeated contended rounds: grants alternate m0, m1, m0, m1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, m0_read held, waitrequest stuck at 1.
  - Response: timeout rises on the 4th stall cycle; m0_readdatavalid pulses with 0xDEADBEEF; timeout stays 1 until reset.
- Reset mid-read:
  - Stimulus: assert reset low while in BUSY.
  - Response: read=0 and m*_waitrequest=1 immediately; no readdatavalid after release; the next request is granted normally.
